// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, 3-sample majority voting,
// per-character error flags and a first-word-fall-through receive FIFO.
//
// Handshake: an entry is offered while rx_valid is high. It is consumed at a
// rising clk edge where rx_valid && rx_ready. rx_data and the flags hold
// steady until that edge, and rx_ready is ignored while rx_valid is low.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [31:0]                       baud_div,
    input  logic                              rx_pin,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_frame_err,
    output logic                              rx_parity_err,
    output logic                              rx_break,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              rx_busy,
    output logic                              rx_overrun,
    input  logic                              ovr_clr,
    output logic [2:0]                        dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    // Entry layout: {break, parity_err, frame_err, data}
    localparam int EW = DATA_BITS + 3;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_WAIT_HIGH = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_PARITY    = 3'd4,
        S_STOP      = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Synchroniser and edge detector
    logic       r_sync1;
    logic       r_rxs;
    logic       r_rxs_prev;
    logic [1:0] r_sync_vld;   // r_sync_vld[1]: r_rxs holds a real post-reset sample
    logic       w_start_edge;

    // Bit timing and frame accumulation
    logic [31:0]          r_div;
    logic [31:0]          r_cnt;
    logic [3:0]           r_bit_idx;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_par_vote;
    logic                 r_par_err;
    logic                 r_stop_all1;
    logic                 r_stop_any1;

    logic [31:0] w_div_eff;
    logic [31:0] w_h;
    logic        w_at_s0;
    logic        w_at_s1;
    logic        w_at_dec;
    logic        w_at_end;
    logic        w_vote;
    logic        w_par_err;
    logic        w_stop_all1;
    logic        w_stop_any1;
    logic        w_frame_err;
    logic        w_break;
    logic        w_push;

    // FIFO
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          r_overrun;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_entry;

    // Two-flop synchroniser; also remembers the previous synced value for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_sync_vld <= 2'b00;
        end else begin
            r_sync1    <= rx_pin;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    assign w_start_edge = r_rxs_prev & ~r_rxs;
    assign w_div_eff    = (baud_div < 32'd4) ? 32'd4 : baud_div;
    assign w_h          = {1'b0, r_div[31:1]};
    assign w_at_s0      = (r_cnt == w_h - 32'd1);
    assign w_at_s1      = (r_cnt == w_h);
    assign w_at_dec     = (r_cnt == w_h + 32'd1);
    assign w_at_end     = (r_cnt == r_div - 32'd1);
    // Third sample is the live synced value at the decision point
    assign w_vote       = (r_samp_a & r_samp_b) | (r_samp_a & r_rxs) | (r_samp_b & r_rxs);
    assign w_par_err    = (^r_data) ^ w_vote ^ ((PARITY == 2) ? 1'b1 : 1'b0);
    assign w_stop_all1  = r_stop_all1 & w_vote;
    assign w_stop_any1  = r_stop_any1 | w_vote;
    assign w_frame_err  = ~w_stop_all1;
    assign w_break      = (r_data == '0) && ((PARITY == 0) || !r_par_vote) && !w_stop_any1;
    assign w_entry      = {w_break, r_par_err, w_frame_err, r_data};

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_WAIT_HIGH;
        else      r_state <= w_state_nxt;
    end

    // FSM next state; the push fires at the decision point of the last stop bit
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            S_WAIT_HIGH: begin
                if (r_sync_vld[1] && r_rxs) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (w_start_edge) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_at_dec && w_vote) w_state_nxt = S_IDLE;
                else if (w_at_end)      w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_at_end && (r_bit_idx == LAST_DATA))
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_at_end) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_at_dec && (r_bit_idx == LAST_STOP)) begin
                    w_push      = 1'b1;
                    w_state_nxt = w_stop_all1 ? S_IDLE : S_WAIT_HIGH;
                end
            end
            default: w_state_nxt = S_WAIT_HIGH;
        endcase
    end

    assign rx_busy   = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);
    assign dbg_state = r_state;

    // Bit counter, mid-bit samples, data shift register and per-frame flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div       <= 32'd4;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_samp_a    <= 1'b1;
            r_samp_b    <= 1'b1;
            r_data      <= '0;
            r_par_vote  <= 1'b0;
            r_par_err   <= 1'b0;
            r_stop_all1 <= 1'b1;
            r_stop_any1 <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_start_edge) begin
                r_div       <= w_div_eff;
                r_cnt       <= '0;
                r_bit_idx   <= '0;
                r_par_vote  <= 1'b0;
                r_par_err   <= 1'b0;
                r_stop_all1 <= 1'b1;
                r_stop_any1 <= 1'b0;
            end
        end else if (rx_busy) begin
            r_cnt <= w_at_end ? '0 : r_cnt + 32'd1;
            if (w_at_s0) r_samp_a <= r_rxs;
            if (w_at_s1) r_samp_b <= r_rxs;
            if (w_at_dec) begin
                if (r_state == S_DATA) r_data <= {w_vote, r_data[DATA_BITS-1:1]};
                if (r_state == S_PARITY) begin
                    r_par_vote <= w_vote;
                    r_par_err  <= w_par_err;
                end
                if (r_state == S_STOP) begin
                    r_stop_all1 <= w_stop_all1;
                    r_stop_any1 <= w_stop_any1;
                end
            end
            if (w_at_end && ((r_state == S_DATA) || (r_state == S_STOP)))
                r_bit_idx <= ((r_state == S_DATA) && (r_bit_idx == LAST_DATA)) ?
                             4'd0 : r_bit_idx + 4'd1;
        end
    end

    assign w_full    = (r_count == LW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = rx_ready && !w_empty;
    // A full FIFO still accepts a push when the head leaves on the same edge
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;

    // FIFO storage; no reset needed since reads are gated by the level
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_entry;
    end

    // FIFO pointers, level and sticky overrun (set has priority over clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop)      r_count <= r_count + LW'(1);
            else if (!w_push_ok && w_pop) r_count <= r_count - LW'(1);
            if (w_drop)       r_overrun <= 1'b1;
            else if (ovr_clr) r_overrun <= 1'b0;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign rx_valid      = !w_empty;
    assign rx_data       = rx_valid ? w_head[DATA_BITS-1:0] : '0;
    assign rx_frame_err  = rx_valid & w_head[EW-3];
    assign rx_parity_err = rx_valid & w_head[EW-2];
    assign rx_break      = rx_valid & w_head[EW-1];
    assign fifo_level    = r_count;
    assign rx_overrun    = r_overrun;

endmodule
